// File: rtl/log_sched_if.sv
// log_sched_if: requester-side request/response bundle of the shared ln scheduler.
interface log_sched_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [15:0]        rsp_data;
    logic               rsp_oor;

    // Requester side: issues operands, consumes results.
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_oor
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_oor
    );
endinterface

// File: rtl/log_sched.sv
// log_sched: round-robin front end sharing one pipelined ln(1+x) unit between NREQ requesters.
// The operand is held on the unit until its pipeline has settled, then the result is
// captured and returned to the granted requester over its response channel.
module log_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned N_STAGE = 2,
    parameter int unsigned SETTLE  = N_STAGE + 2
) (
    input  logic        clk,
    input  logic        rst_n,
    log_sched_if.slave  bus,
    output logic        log_rst_o,
    output logic [15:0] log_data_o,
    input  logic [15:0] log_result_i,
    output logic        busy_o
);
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Never sample before the pipeline has produced the held operand's result.
    localparam int unsigned HOLD_CYC = (SETTLE > N_STAGE) ? SETTLE : N_STAGE + 1;
    localparam int unsigned CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [DATA_W:0]   OOR_LIM  = (DATA_W + 1)'(1024);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q,  grant_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [DATA_W-1:0] rsp_q,    rsp_d;
    logic              oor_q,    oor_d;

    logic              win_vld_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic [DATA_W-1:0] win_data_c;
    logic [DATA_W:0]   x_ext_c;
    logic [DATA_W:0]   x_abs_c;

    // Round-robin winner: first valid at or above rr_ptr, else first valid from 0.
    always_comb begin
        win_vld_c  = 1'b0;
        win_idx_c  = '0;
        win_data_c = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!win_vld_c && bus.req_valid[j] && (32'(rr_ptr_q) <= j)) begin
                win_vld_c  = 1'b1;
                win_idx_c  = IDX_W'(j);
                win_data_c = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!win_vld_c && bus.req_valid[j]) begin
                win_vld_c  = 1'b1;
                win_idx_c  = IDX_W'(j);
                win_data_c = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Magnitude of the held operand in 17 bits so that -32.0 does not wrap.
    assign x_ext_c = {data_q[DATA_W-1], data_q};
    assign x_abs_c = data_q[DATA_W-1] ? -x_ext_c : x_ext_c;

    // Next-state and handshake decode.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        rsp_d         = rsp_q;
        oor_d         = oor_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (win_vld_c) begin
                    bus.req_ready = NREQ'(1) << win_idx_c;
                    data_d        = win_data_c;
                    grant_d       = win_idx_c;
                    cnt_d         = CNT_LOAD;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    rsp_d   = log_result_i;
                    oor_d   = (x_abs_c >= OOR_LIM);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                bus.rsp_valid = NREQ'(1) << grant_q;
                if (bus.rsp_ready[grant_q]) begin
                    rr_ptr_d = IDX_W'((32'(grant_q) + 32'd1) % NREQ);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            rsp_q    <= '0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rsp_q    <= rsp_d;
            oor_q    <= oor_d;
        end
    end

    assign log_rst_o    = (state_q == ST_INIT);
    assign busy_o       = (state_q != ST_IDLE);
    assign log_data_o   = data_q;
    assign bus.rsp_data = rsp_q;
    assign bus.rsp_oor  = oor_q;
endmodule

// File: tb/tb_log_sched.sv
// tb_log_sched: vector table, corner-case sequences and random traffic for log_sched.
module tb_log_sched;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned N_STAGE = 2;
    localparam int unsigned SETTLE  = N_STAGE + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        log_rst;
    logic [15:0] log_data;
    logic [15:0] log_result;
    logic        busy;

    log_sched_if #(.NREQ(NREQ)) bus ();

    log_sched #(.NREQ(NREQ), .N_STAGE(N_STAGE), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .log_rst_o    (log_rst),
        .log_data_o   (log_data),
        .log_result_i (log_result),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_err    = 0;
    int model_rr = 0;

    // Golden ln(1+x) in 5.10; out-of-range operands map to a distinct pattern.
    function automatic logic [15:0] ln_fx(input logic [15:0] x);
        int  v;
        real r;
        v = $signed(x);
        if (v >= 1024 || v <= -1024) return x ^ 16'h5A5A;
        r = $ln(1.0 + $itor(v) / 1024.0) * 1024.0;
        return 16'($rtoi(r));
    endfunction

    function automatic logic oor_ref(input logic [15:0] x);
        int v;
        v = $signed(x);
        return (v >= 1024) || (v <= -1024);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int exp_winner(input logic [NREQ-1:0] mask, input int rr);
        for (int i = 0; i < int'(NREQ); i++) begin
            int c;
            c = (rr + i) % int'(NREQ);
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] edges [8] = '{16'h0400, 16'hFC00, 16'h8000, 16'h03FF,
                                   16'hFC01, 16'h7FFF, 16'h0000, 16'hFFFF};
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    // Pipelined ln unit stand-in: N_STAGE register stages, synchronous reset.
    logic [15:0] ln_pipe [N_STAGE];
    always_ff @(posedge clk) begin
        if (log_rst) begin
            for (int unsigned k = 0; k < N_STAGE; k++) ln_pipe[k] <= '0;
        end else begin
            ln_pipe[0] <= ln_fx(log_data);
            for (int unsigned k = 1; k < N_STAGE; k++) ln_pipe[k] <= ln_pipe[k-1];
        end
    end
    assign log_result = ln_pipe[N_STAGE-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".log_rst"},   32'(log_rst),       32'd1);
        check({nm, ".busy"},      32'(busy),          32'd1);
        check({nm, ".req_ready"}, 32'(bus.req_ready), 32'd0);
        check({nm, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({nm, ".rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({nm, ".rsp_oor"},   32'(bus.rsp_oor),   32'd0);
        check({nm, ".log_data"},  32'(log_data),      32'd0);
    endtask

    task automatic assert_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        @(negedge clk);
        check_reset_outputs("rst_a");
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst_b");
    endtask

    // Release: exactly one INIT cycle with LOG_RST high, then IDLE.
    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = {16'h0111, 16'h0222};
        @(negedge clk);
        check("init.log_rst",   32'(log_rst),       32'd1);
        check("init.busy",      32'(busy),          32'd1);
        check("init.req_ready", 32'(bus.req_ready), 32'd0);
        check("init.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("idle.log_rst",   32'(log_rst),       32'd0);
        check("idle.busy",      32'(busy),          32'd0);
        check("idle.req_ready", 32'(bus.req_ready), 32'd0);
        check("idle.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        model_rr = 0;
    endtask

    task automatic apply_reset();
        assert_reset();
        release_reset();
    endtask

    // One transaction: accept cycle, SETTLE hold cycles, response after bp stalled cycles.
    task automatic run_op(input string nm, input logic [NREQ-1:0] mask,
                          input logic [16*NREQ-1:0] dv, input int bp, input int w,
                          input logic [15:0] exp_rsp, input logic exp_oor);
        logic [15:0]     opnd;
        logic [NREQ-1:0] oh;
        opnd = dv[16*w +: 16];
        oh   = onehot(w);
        @(posedge clk); #1;
        bus.req_valid = mask;
        bus.req_data  = dv;
        bus.rsp_ready = '0;
        @(negedge clk);
        check({nm, ".accept_ready"}, 32'(bus.req_ready), 32'(oh));
        check({nm, ".idle_rsp_vld"}, 32'(bus.rsp_valid), 32'd0);
        check({nm, ".idle_busy"},    32'(busy),          32'd0);
        @(posedge clk); #1;
        bus.req_valid = mask & ~oh;
        for (int c = 1; c <= int'(SETTLE); c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            check({nm, ".hold_rsp_vld"}, 32'(bus.rsp_valid), 32'd0);
            check({nm, ".hold_ready"},   32'(bus.req_ready), 32'd0);
            check({nm, ".hold_logdata"}, 32'(log_data),      32'(opnd));
            check({nm, ".hold_busy"},    32'(busy),          32'd1);
        end
        for (int c = 0; c <= bp; c++) begin
            @(posedge clk); #1;
            if (c == bp) bus.rsp_ready = oh | NREQ'($urandom);
            else         bus.rsp_ready = NREQ'($urandom) & ~oh;
            @(negedge clk);
            check({nm, ".rsp_valid"},   32'(bus.rsp_valid), 32'(oh));
            check({nm, ".rsp_data"},    32'(bus.rsp_data),  32'(exp_rsp));
            check({nm, ".rsp_oor"},     32'(bus.rsp_oor),   32'(exp_oor));
            check({nm, ".rsp_logdata"}, 32'(log_data),      32'(opnd));
            check({nm, ".rsp_ready0"},  32'(bus.req_ready), 32'd0);
        end
        model_rr = (w + 1) % int'(NREQ);
    endtask

    typedef struct {
        int          req;
        logic [15:0] data;
        int          bp;
        logic [15:0] exp_rsp;
        logic        exp_oor;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [16*NREQ-1:0] dv;
        int                 gq[$];
        int                 gc[$];
        int                 rq[$];
        logic [15:0]        rd[$];

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;

        vecs[0] = '{0, 16'h0100, 0, ln_fx(16'h0100), 1'b0};
        vecs[1] = '{1, 16'h0400, 1, 16'h0400 ^ 16'h5A5A, 1'b1};
        vecs[2] = '{0, 16'hFC00, 0, 16'hFC00 ^ 16'h5A5A, 1'b1};
        vecs[3] = '{1, 16'h8000, 2, 16'h8000 ^ 16'h5A5A, 1'b1};
        vecs[4] = '{0, 16'h03FF, 0, ln_fx(16'h03FF), 1'b0};
        vecs[5] = '{1, 16'hFC01, 0, ln_fx(16'hFC01), 1'b0};
        vecs[6] = '{0, 16'h0000, 1, 16'h0000, 1'b0};
        vecs[7] = '{1, 16'h7FFF, 0, 16'h7FFF ^ 16'h5A5A, 1'b1};

        apply_reset();

        // Vector table: single requester per transaction, range-flag boundaries.
        for (int i = 0; i < 8; i++) begin
            dv = {16'($urandom), 16'($urandom)};
            dv[16*vecs[i].req +: 16] = vecs[i].data;
            run_op("vec", onehot(vecs[i].req), dv, vecs[i].bp, vecs[i].req,
                   vecs[i].exp_rsp, vecs[i].exp_oor);
        end

        // Backpressure on requester 0 while requester 1 keeps asking.
        apply_reset();
        run_op("bp0", 2'b11, {16'h0333, 16'h0155}, 10, 0, ln_fx(16'h0155), 1'b0);
        run_op("bp1", 2'b10, {16'h0333, 16'h0155}, 0, 1, ln_fx(16'h0333), 1'b0);

        // Contention: both valid and both ready held for 24 cycles.
        apply_reset();
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        bus.req_data  = {16'h0200, 16'h0100};
        bus.rsp_ready = 2'b11;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            for (int r = 0; r < int'(NREQ); r++) begin
                if (bus.req_ready[r]) begin gq.push_back(r); gc.push_back(cyc); end
                if (bus.rsp_valid[r]) begin rq.push_back(r); rd.push_back(bus.rsp_data); end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        check("rr.grant_count", 32'(gq.size()), 32'd4);
        check("rr.rsp_count",   32'(rq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) begin
                check("rr.grant_order", 32'(gq[i]), 32'(i % 2));
                check("rr.grant_cycle", 32'(gc[i]), 32'(i * (int'(SETTLE) + 2)));
            end
            if (i < rq.size()) begin
                check("rr.rsp_owner", 32'(rq[i]), 32'(i % 2));
                check("rr.rsp_data",  32'(rd[i]),
                      32'(ln_fx((i % 2 == 1) ? 16'h0200 : 16'h0100)));
            end
        end
        model_rr = 0;

        // Reset while holding requester 1's operand at cnt==1.
        apply_reset();
        run_op("pre", 2'b01, {16'h0011, 16'h0200}, 0, 0, ln_fx(16'h0200), 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.req_data  = {16'h0123, 16'h0000};
        bus.rsp_ready = '0;
        @(negedge clk);
        check("hrst.accept", 32'(bus.req_ready), 32'(2'b10));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("hrst");
        @(posedge clk); #1;
        @(negedge clk);
        check("hrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        release_reset();
        run_op("post", 2'b11, {16'h0040, 16'h0020}, 0, exp_winner(2'b11, model_rr),
               ln_fx(16'h0020), 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] m;
            int              w;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int r = 0; r < int'(NREQ); r++) dv[16*r +: 16] = pick_operand();
            w = exp_winner(m, model_rr);
            run_op("rnd", m, dv, int'($urandom_range(0, 3)), w,
                   ln_fx(dv[16*w +: 16]), oor_ref(dv[16*w +: 16]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
